act_fetch_buf: RTL and testbench
================================

// Module: act_fetch_buf
// PURPOSE
//  Activation fetch stage directly downstream of the activation loop controller.
//  Turns each controller fetch pulse into one activation-SRAM read and buffers returned words in a small FIFO.
//  Presents words to the PE array with a valid/ready handshake and returns the controller's GetAct pulse
//  on every word the PE consumes, closing the fetch loop. Row/block position flags travel with each word.
// PARAMETERS
//  ACT_WIDTH   128  activation word width (bits)
//  ADDR_WIDTH  12   activation SRAM address width
//  DEPTH       4    FIFO entries; power of 2, >=2
//  ROW_WIDTH   8    width of CFG_LenRow, equal to C_LOG_2(LENROW)
// PORTS
//  clk               in   1           clock, all logic on rising edge
//  rst_n             in   1           synchronous reset, active-low
//  CFG_BaseAddr      in   ADDR_WIDTH  first SRAM address of the block; static while not IDLE
//  CTRLACT_PlsFetch  in   1           fetch request pulse from controller
//  CTRLACT_FrtActRow in   1           current fetch is first of row (sampled with PlsFetch)
//  CTRLACT_LstActRow in   1           current fetch is last of row (sampled with PlsFetch)
//  CTRLACT_LstActBlk in   1           current fetch is last of block (sampled with PlsFetch)
//  CTRLACT_GetAct    out  1           one-cycle pulse per word handed to PE
//  ACT_RdEn          out  1           SRAM read enable
//  ACT_RdAddr        out  ADDR_WIDTH  SRAM read address
//  ACT_RdDat         in   ACT_WIDTH   SRAM read data, valid exactly 1 cycle after ACT_RdEn
//  PE_ActVld         out  1           FIFO head valid
//  PE_ActRdy         in   1           PE accepts head when PE_ActVld && PE_ActRdy
//  PE_ActDat         out  ACT_WIDTH   FIFO head data
//  PE_ActFlg         out  3           head flags {LstActBlk, LstActRow, FrtActRow}
//  ACTFB_Busy        out  1           state != IDLE
//  ACTFB_ErrOvf      out  1           sticky: PlsFetch dropped for lack of credit
// BEHAVIOUR
//  Reset (rst_n==0 at a clock edge): every output 0, FIFO empty, in-flight cleared, state IDLE.
//   Reset mid-operation discards buffered words and in-flight reads; the SRAM return following reset is ignored.
//  Credit: Occ (FIFO count, 0..DEPTH) + InFlt (0/1) < DEPTH, evaluated on registered values;
//   a same-cycle pop does not add credit.
//  Accept: PlsFetch && credit -> ACT_RdEn=1 combinationally in the same cycle, ACT_RdAddr=AddrReg.
//   The 3 flags are captured into a 1-stage side pipe.
//  No credit: the pulse is dropped, no read, ACT_ErrOvf set until reset.
//  Return: 1 cycle after ACT_RdEn, ACT_RdDat and the piped flags are pushed into the FIFO.
//   Push is never blocked, guaranteed by credit.
//  Pop: PE_ActVld && PE_ActRdy. CTRLACT_GetAct = pop (combinational, same cycle).
//  Push and pop in the same cycle: Occ unchanged; the pop takes the old head. With Occ==0, push makes head valid next cycle (no bypass).
//  Latency: PlsFetch at cycle t -> PE_ActVld earliest at t+2.
//  Address: AddrReg <= CFG_BaseAddr in IDLE; +1 per accepted read, wrapping modulo 2^ADDR_WIDTH.
//   An accepted read flagged LstActBlk reloads CFG_BaseAddr.
//  FSM:
//   IDLE  -> RUN   on an accepted PlsFetch.
//   RUN   -> FLUSH on an accepted read with LstActBlk=1.
//   FLUSH : further PlsFetch counts as no credit and is dropped with ErrOvf.
//   FLUSH -> IDLE  when Occ==0 and InFlt==0.
//   Read-with-LstActBlk from IDLE (1-word block): IDLE->FLUSH directly.
//  PE_ActDat/PE_ActFlg hold the head entry when PE_ActVld==1; they are don't-care when PE_ActVld==0.
// TESTING
//  T1 reset: drive rst_n=0 mid-RUN with Occ=3 -> next cycle Vld=0, Busy=0, RdEn=0, ErrOvf=0; stale ACT_RdDat not pushed.
//  T2 single fetch: BaseAddr=0x100, PlsFetch at t with FrtActRow=1, PE_ActRdy=1.
//     -> RdEn/RdAddr=0x100 at t; Vld at t+2; Flg=3'b001; GetAct at t+2.
//  T3 closed loop, LenRow=3 (4 words), PlsFetch = GetAct || start, PE_ActRdy=1.
//     -> addresses 0x100..0x103 in order; last word Flg=3'b110 with LstActBlk;
//     -> FLUSH then IDLE; next block restarts at 0x100.
//  T4 backpressure: PE_ActRdy=0, 6 pulses, DEPTH=4 -> exactly 4 reads, ErrOvf=1, Occ=4;
//     -> release Rdy: 4 GetAct pulses in order, data matches SRAM model.
//  T5 simultaneous: Occ=2, push and pop same cycle -> Occ stays 2, FIFO order preserved.
//  T6 wrap: BaseAddr=0xFFF, 2 fetches -> RdAddr 0xFFF then 0x000.

Source files
------------

// File: rtl/act_fetch_buf_if.sv
// Bus bundle for act_fetch_buf.
// Carries the controller fetch/flag pulses, the activation SRAM read port and
// the PE valid/ready word stream.
//   master : the fetch buffer itself (drives reads, PE data, status)
//   slave  : the environment (controller, SRAM, PE array)
interface act_fetch_buf_if #(
  parameter int ACT_WIDTH  = 128,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] CFG_BaseAddr;
  logic                  CTRLACT_PlsFetch;
  logic                  CTRLACT_FrtActRow;
  logic                  CTRLACT_LstActRow;
  logic                  CTRLACT_LstActBlk;
  logic                  CTRLACT_GetAct;
  logic                  ACT_RdEn;
  logic [ADDR_WIDTH-1:0] ACT_RdAddr;
  logic [ACT_WIDTH-1:0]  ACT_RdDat;
  logic                  PE_ActVld;
  logic                  PE_ActRdy;
  logic [ACT_WIDTH-1:0]  PE_ActDat;
  logic [2:0]            PE_ActFlg;
  logic                  ACTFB_Busy;
  logic                  ACTFB_ErrOvf;

  modport master (
    input  CFG_BaseAddr, CTRLACT_PlsFetch, CTRLACT_FrtActRow, CTRLACT_LstActRow,
           CTRLACT_LstActBlk, ACT_RdDat, PE_ActRdy,
    output CTRLACT_GetAct, ACT_RdEn, ACT_RdAddr, PE_ActVld, PE_ActDat, PE_ActFlg,
           ACTFB_Busy, ACTFB_ErrOvf
  );

  modport slave (
    output CFG_BaseAddr, CTRLACT_PlsFetch, CTRLACT_FrtActRow, CTRLACT_LstActRow,
           CTRLACT_LstActBlk, ACT_RdDat, PE_ActRdy,
    input  CTRLACT_GetAct, ACT_RdEn, ACT_RdAddr, PE_ActVld, PE_ActDat, PE_ActFlg,
           ACTFB_Busy, ACTFB_ErrOvf
  );
endinterface

// File: rtl/act_fetch_buf.sv
// Activation fetch stage.
// Each accepted controller fetch pulse issues one activation-SRAM read; the
// word returns one cycle later and is queued, with its row/block flags, in a
// DEPTH-entry FIFO that feeds the PE array over valid/ready. Every word the PE
// takes produces a GetAct pulse back to the controller.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : act_fetch_buf_if.master (controller, SRAM read port, PE stream, status)
module act_fetch_buf #(
  parameter int ACT_WIDTH  = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter int ROW_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  act_fetch_buf_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ROW_WIDTH < 1) begin : gBadParam
    $error("act_fetch_buf: DEPTH must be a power of 2 >= 2, ROW_WIDTH >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [2:0]           flg;
    logic [ACT_WIDTH-1:0] dat;
  } entry_t;

  state_t                state, stateNxt;
  entry_t                mem [DEPTH];
  logic [PTR_W-1:0]      wrPtr, rdPtr;
  logic [CNT_W-1:0]      occ;
  logic                  inFlt;     // read issued last cycle, data on ACT_RdDat now
  logic [2:0]            flgPipe;   // flags of the in-flight read
  logic [ADDR_WIDTH-1:0] addrReg;
  logic                  errOvf;
  logic [CNT_W:0]        used;
  logic                  credit, accept, push, pop, lstBlk;

  // Credit uses registered occupancy only: a pop in this cycle frees its slot
  // next cycle, keeping the accept path off the PE ready input.
  assign used   = {1'b0, occ} + (CNT_W + 1)'(inFlt);
  assign credit = (used < (CNT_W + 1)'(DEPTH)) && (state != FLUSH);
  assign accept = rst_n && bus.CTRLACT_PlsFetch && credit;
  assign lstBlk = bus.CTRLACT_LstActBlk;
  assign push   = inFlt;
  assign pop    = (occ != '0) && bus.PE_ActRdy;

  assign bus.ACT_RdEn       = accept;
  assign bus.ACT_RdAddr     = addrReg;
  assign bus.PE_ActVld      = (occ != '0);
  assign bus.PE_ActDat      = mem[rdPtr].dat;
  assign bus.PE_ActFlg      = mem[rdPtr].flg;
  assign bus.CTRLACT_GetAct = pop;
  assign bus.ACTFB_Busy     = (state != IDLE);
  assign bus.ACTFB_ErrOvf   = errOvf;

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (accept) stateNxt = lstBlk ? FLUSH : RUN;
      RUN:     if (accept && lstBlk) stateNxt = FLUSH;
      FLUSH:   if (occ == '0 && !inFlt) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wrPtr   <= '0;
      rdPtr   <= '0;
      occ     <= '0;
      inFlt   <= 1'b0;
      flgPipe <= '0;
      addrReg <= '0;
      errOvf  <= 1'b0;
    end else begin
      state <= stateNxt;
      inFlt <= accept;
      if (accept) flgPipe <= {bus.CTRLACT_LstActBlk, bus.CTRLACT_LstActRow, bus.CTRLACT_FrtActRow};
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: ;
      endcase
      // Last read of a block rewinds to the base so the next block needs no IDLE cycle.
      if (accept)
        addrReg <= lstBlk ? bus.CFG_BaseAddr : addrReg + ADDR_WIDTH'(1);
      else if (state == IDLE)
        addrReg <= bus.CFG_BaseAddr;
      if (bus.CTRLACT_PlsFetch && !accept) errOvf <= 1'b1;
    end
  end

  // Storage has no reset; only pointers/occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wrPtr] <= '{flg: flgPipe, dat: bus.ACT_RdDat};
  end
endmodule

// File: tb/tb_act_fetch_buf.sv
module tb_act_fetch_buf;
  typedef logic [131:0] cv_t;

  typedef struct {
    bit          rst;
    logic [11:0] base;
    bit          pls, fr, lr, lb, rdy;
    bit          eRd;
    logic [11:0] eAddr;
    bit          eVld, eGa, eBusy, eErr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [11:0]  addrQ[$];
  logic [130:0] dataQ[$];
  vec_t         vt[14];

  act_fetch_buf_if #(.ACT_WIDTH(128), .ADDR_WIDTH(12)) bus ();

  act_fetch_buf #(.ACT_WIDTH(128), .ADDR_WIDTH(12), .DEPTH(4), .ROW_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] dataOf(input logic [11:0] a);
    return {4{20'hC0DE0, a}};
  endfunction

  // SRAM model: registered read, data valid one cycle after RdEn
  always @(posedge clk) if (bus.ACT_RdEn) bus.ACT_RdDat <= dataOf(bus.ACT_RdAddr);

  task automatic check(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectRead(input logic [11:0] a, input logic [2:0] f);
    addrQ.push_back(a);
    dataQ.push_back({f, dataOf(a)});
  endtask

  task automatic drive(input bit pls, input bit fr, input bit lr, input bit lb, input bit rdy);
    bus.CTRLACT_PlsFetch  = pls;
    bus.CTRLACT_FrtActRow = fr;
    bus.CTRLACT_LstActRow = lr;
    bus.CTRLACT_LstActBlk = lb;
    bus.PE_ActRdy         = rdy;
  endtask

  task automatic doReset(input logic [11:0] base);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.CFG_BaseAddr = base;
    drive(0, 0, 0, 0, 0);
    addrQ.delete();
    dataQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: reads checked against expected addresses, pops against queued words
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ACT_RdEn) begin
        if (addrQ.size() == 0) check("rd_unexpected", cv_t'(bus.ACT_RdEn), cv_t'(0));
        else check("rd_addr", cv_t'(bus.ACT_RdAddr), cv_t'(addrQ.pop_front()));
      end
      check("getact_eq_pop", cv_t'(bus.CTRLACT_GetAct), cv_t'(bus.PE_ActVld && bus.PE_ActRdy));
      if (bus.PE_ActVld && bus.PE_ActRdy) begin
        if (dataQ.size() == 0) check("pop_unexpected", cv_t'(bus.PE_ActVld), cv_t'(0));
        else check("pop_word", cv_t'({bus.PE_ActFlg, bus.PE_ActDat}), cv_t'(dataQ.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst base    pls fr lr lb rdy eRd eAddr   vld ga busy err
    // single fetch from IDLE, first-of-row
    vt[0]  = '{1, 12'h100, 0, 0, 0, 0, 1,  0, 12'h000, 0, 0, 0, 0};
    vt[1]  = '{0, 12'h100, 1, 1, 0, 0, 1,  1, 12'h100, 0, 0, 0, 0};
    vt[2]  = '{0, 12'h100, 0, 0, 0, 0, 1,  0, 12'h000, 0, 0, 1, 0};
    vt[3]  = '{0, 12'h100, 0, 0, 0, 0, 1,  0, 12'h000, 1, 1, 1, 0};
    vt[4]  = '{0, 12'h100, 0, 0, 0, 0, 1,  0, 12'h000, 0, 0, 1, 0};
    // address wrap, 2-word block, drop in FLUSH, restart at base
    vt[5]  = '{1, 12'hFFF, 1, 1, 0, 0, 1,  1, 12'hFFF, 0, 0, 0, 0};
    vt[6]  = '{0, 12'hFFF, 1, 0, 1, 1, 1,  1, 12'h000, 0, 0, 1, 0};
    vt[7]  = '{0, 12'hFFF, 0, 0, 0, 0, 1,  0, 12'h000, 1, 1, 1, 0};
    vt[8]  = '{0, 12'hFFF, 1, 0, 0, 0, 1,  0, 12'h000, 1, 1, 1, 0};
    vt[9]  = '{0, 12'hFFF, 0, 0, 0, 0, 1,  0, 12'h000, 0, 0, 1, 1};
    vt[10] = '{0, 12'hFFF, 0, 0, 0, 0, 1,  0, 12'h000, 0, 0, 0, 1};
    vt[11] = '{0, 12'hFFF, 1, 0, 0, 0, 1,  1, 12'hFFF, 0, 0, 0, 1};
    vt[12] = '{0, 12'hFFF, 0, 0, 0, 0, 1,  0, 12'h000, 0, 0, 1, 1};
    vt[13] = '{0, 12'hFFF, 0, 0, 0, 0, 1,  0, 12'h000, 1, 1, 1, 1};

    rst_n = 1'b0;
    bus.CFG_BaseAddr = 12'h000;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld",    cv_t'(bus.PE_ActVld),      cv_t'(0));
    check("rst_busy",   cv_t'(bus.ACTFB_Busy),     cv_t'(0));
    check("rst_rden",   cv_t'(bus.ACT_RdEn),       cv_t'(0));
    check("rst_err",    cv_t'(bus.ACTFB_ErrOvf),   cv_t'(0));
    check("rst_getact", cv_t'(bus.CTRLACT_GetAct), cv_t'(0));

    // ---- table-driven vectors ----
    for (int i = 0; i < 14; i++) begin
      if (vt[i].rst) doReset(vt[i].base);
      @(posedge clk); #1;
      bus.CFG_BaseAddr = vt[i].base;
      drive(vt[i].pls, vt[i].fr, vt[i].lr, vt[i].lb, vt[i].rdy);
      if (vt[i].eRd) expectRead(vt[i].eAddr, {vt[i].lb, vt[i].lr, vt[i].fr});
      @(negedge clk);
      check($sformatf("v%0d_rden", i),   cv_t'(bus.ACT_RdEn),       cv_t'(vt[i].eRd));
      check($sformatf("v%0d_vld", i),    cv_t'(bus.PE_ActVld),      cv_t'(vt[i].eVld));
      check($sformatf("v%0d_getact", i), cv_t'(bus.CTRLACT_GetAct), cv_t'(vt[i].eGa));
      check($sformatf("v%0d_busy", i),   cv_t'(bus.ACTFB_Busy),     cv_t'(vt[i].eBusy));
      check($sformatf("v%0d_err", i),    cv_t'(bus.ACTFB_ErrOvf),   cv_t'(vt[i].eErr));
    end

    // ---- closed loop, 4-word block, run twice ----
    doReset(12'h100);
    for (int blk = 0; blk < 2; blk++) begin
      int  issued;
      int  got;
      int  n;
      bit  start;
      bit  last;
      issued = 0;
      got    = 0;
      start  = 1;
      for (int c = 0; c < 60 && got < 4; c++) begin
        @(posedge clk); #1;
        if ((start || bus.CTRLACT_GetAct) && issued < 4) begin
          last = (issued == 3);
          drive(1, issued == 0, last, last, 1);
          expectRead(12'(32'h100 + issued), {last, last, issued == 0});
          issued++;
        end else begin
          drive(0, 0, 0, 0, 1);
        end
        start = 0;
        @(negedge clk);
        if (bus.CTRLACT_GetAct) got++;
      end
      check($sformatf("t3_b%0d_words", blk), cv_t'(got), cv_t'(4));
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1);
      n = 0;
      @(negedge clk);
      while (bus.ACTFB_Busy && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("t3_b%0d_idle", blk), cv_t'(bus.ACTFB_Busy), cv_t'(0));
      check($sformatf("t3_b%0d_err", blk),  cv_t'(bus.ACTFB_ErrOvf), cv_t'(0));
    end
    check("t3_drained", cv_t'(addrQ.size() + dataQ.size()), cv_t'(0));

    // ---- backpressure: 6 pulses, only DEPTH accepted ----
    begin
      int cnt;
      doReset(12'h100);
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        drive(1, i == 0, 0, 0, 0);
        if (i < 4) expectRead(12'(32'h100 + i), {2'b00, i == 0});
        @(negedge clk);
        check($sformatf("t4_rden%0d", i), cv_t'(bus.ACT_RdEn), cv_t'(i < 4));
      end
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      check("t4_err", cv_t'(bus.ACTFB_ErrOvf), cv_t'(1));
      check("t4_vld", cv_t'(bus.PE_ActVld),    cv_t'(1));
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.CTRLACT_GetAct) cnt++;
      end
      check("t4_pops",     cv_t'(cnt),              cv_t'(4));
      check("t4_empty",    cv_t'(bus.PE_ActVld),    cv_t'(0));
      check("t4_err_stky", cv_t'(bus.ACTFB_ErrOvf), cv_t'(1));
    end

    // ---- simultaneous push and pop at Occ=2 ----
    doReset(12'h200);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0);
      expectRead(12'(32'h200 + i), 3'b000);
      @(negedge clk);
      check($sformatf("t5_rden%0d", i), cv_t'(bus.ACT_RdEn), cv_t'(1));
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    check("t5_pop0", cv_t'(bus.CTRLACT_GetAct), cv_t'(1));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("t5_hold_vld", cv_t'(bus.PE_ActVld), cv_t'(1));
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      check($sformatf("t5_pop%0d", i), cv_t'(bus.CTRLACT_GetAct), cv_t'(1));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_empty", cv_t'(bus.PE_ActVld), cv_t'(0));
    check("t5_drained", cv_t'(addrQ.size() + dataQ.size()), cv_t'(0));

    // ---- reset mid-RUN with Occ=3 and a read in flight ----
    doReset(12'h300);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0);
      if (i < 4) expectRead(12'(32'h300 + i), 3'b000);
      @(negedge clk);
      check($sformatf("t1_rden%0d", i), cv_t'(bus.ACT_RdEn), cv_t'(i < 4));
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    check("t1_err_pre", cv_t'(bus.ACTFB_ErrOvf),   cv_t'(1));
    check("t1_pop_pre", cv_t'(bus.CTRLACT_GetAct), cv_t'(1));
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0);
    expectRead(12'h304, 3'b000);
    @(negedge clk);
    check("t1_rden_occ3", cv_t'(bus.ACT_RdEn), cv_t'(1));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    addrQ.delete();
    dataQ.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_vld",    cv_t'(bus.PE_ActVld),      cv_t'(0));
    check("t1_busy",   cv_t'(bus.ACTFB_Busy),     cv_t'(0));
    check("t1_rden",   cv_t'(bus.ACT_RdEn),       cv_t'(0));
    check("t1_err",    cv_t'(bus.ACTFB_ErrOvf),   cv_t'(0));
    check("t1_getact", cv_t'(bus.CTRLACT_GetAct), cv_t'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("t1_stale%0d", i), cv_t'(bus.PE_ActVld), cv_t'(0));
    end

    check("final_drained", cv_t'(addrQ.size() + dataQ.size()), cv_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
